// File: rtl/bcd_entry_to_val_if.sv
// Key-entry bundle between the keypad front end and bcd_entry_to_val.
// The master drives keys and strobes; the slave returns the packed word.
interface bcd_entry_to_val_if;
   logic        key_valid;
   logic [3:0]  key;
   logic [1:0]  mode;
   logic        enter;
   logic        clear;
   logic [11:0] val;
   logic        val_valid;
   logic        err;
   logic        busy;

   modport master (
      output key_valid, key, mode, enter, clear,
      input  val, val_valid, err, busy
   );

   modport slave (
      input  key_valid, key, mode, enter, clear,
      output val, val_valid, err, busy
   );
endinterface

// File: rtl/bcd_entry_to_val.sv
// Digit-entry assembler: key codes -> packed 12-bit operand word.
// Optional NEG_ZERO_FIX_EN: commit "-0" operands as +0.
module bcd_entry_to_val #(
   parameter logic [3:0]  NEG_CODE = 4'd10,
   parameter int unsigned MAG8_MAX = 255
) (
   input logic              clk,
   input logic              rst,
   bcd_entry_to_val_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE, OP1, OP2, DONE, ERR
   } state_t;

   state_t      st, st_n;
   logic [1:0]  md, md_n;
   logic [7:0]  acc, acc_n;
   logic        sg, sg_n;
   logic        s1, s1_n;
   logic [3:0]  m1, m1_n;
   logic [2:0]  cnt, cnt_n;
   logic        nk, nk_n;
   logic [11:0] val_n;
   logic        vv_n;
   logic        err_n;
   logic        busy_n;

   logic        is_dig;
   logic        is_neg;
   logic        acc_key;
   logic        run;
   logic        commit;
   logic        bin_k;
   logic        neg_k;
   logic        dig_k;
   logic [11:0] wide;
   logic [11:0] lim;
   logic        fs1;
   logic        fsg;

   // Pack operand fields into the display/operand word.
   function automatic logic [11:0] pack(
      input logic [1:0] f_md,
      input logic       f_s1,
      input logic [3:0] f_m1,
      input logic       f_sg,
      input logic [7:0] f_acc,
      input logic       f_op2
   );
      logic [11:0] w;
      w = 12'hC00;
      case (f_md)
         2'b00: begin
            if (f_op2)
               w = {2'b00, f_s1, f_m1, f_sg, f_acc[3:0]};
            else
               w = {2'b00, f_sg, f_acc[3:0], 5'b0};
         end
         2'b01: w = {2'b01, f_sg, 1'b0, f_acc};
         2'b10: w = {2'b10, 4'b0, f_acc[5:0]};
         default: w = 12'hC00;
      endcase
      return w;
   endfunction

   assign is_dig  = (bus.key <= 4'd9);
   assign is_neg  = (bus.key == NEG_CODE);
   assign acc_key = bus.key_valid && (is_dig || is_neg);

`ifdef NEG_ZERO_FIX_EN
   assign fs1 = s1 && (m1 != 4'd0);
   assign fsg = sg && (acc != 8'd0);
`else
   assign fs1 = s1;
   assign fsg = sg;
`endif

   // Next-state, accumulator update and registered-output values.
   always_comb begin
      st_n   = st;
      md_n   = md;
      acc_n  = acc;
      sg_n   = sg;
      s1_n   = s1;
      m1_n   = m1;
      cnt_n  = cnt;
      nk_n   = nk;
      val_n  = bus.val;
      vv_n   = 1'b0;
      run    = 1'b0;
      commit = 1'b0;
      bin_k  = 1'b0;
      neg_k  = 1'b0;
      dig_k  = 1'b0;
      wide   = '0;
      lim    = '0;

      if (bus.clear) begin
         st_n  = IDLE;
         acc_n = '0;
         sg_n  = 1'b0;
         s1_n  = 1'b0;
         m1_n  = '0;
         cnt_n = '0;
         nk_n  = 1'b0;
      end else if (bus.enter) begin
         if (st == OP1 && md == 2'b00) begin
            st_n  = OP2;
            s1_n  = sg;
            m1_n  = acc[3:0];
            sg_n  = 1'b0;
            acc_n = '0;
            nk_n  = 1'b0;
         end else if (st == OP1 || st == OP2) begin
            st_n   = DONE;
            commit = 1'b1;
         end
      end else if (acc_key) begin
         if (st == IDLE || st == DONE) begin
            md_n  = bus.mode;
            acc_n = '0;
            sg_n  = 1'b0;
            s1_n  = 1'b0;
            m1_n  = '0;
            cnt_n = '0;
            nk_n  = 1'b0;
            if (bus.mode == 2'b11) begin
               st_n = ERR;
            end else begin
               st_n = OP1;
               run  = 1'b1;
            end
         end else if (st == OP1 || st == OP2) begin
            run = 1'b1;
         end
      end

      if (run) begin
         bin_k = (md_n == 2'b10);
         neg_k = !bin_k && is_neg;
         dig_k = !bin_k && !is_neg;
         lim   = (md_n == 2'b00) ? 12'd15
                                 : 12'(MAG8_MAX);
         wide  = ({4'd0, acc_n} * 12'd10)
               + {8'd0, bus.key};
         unique case (1'b1)
            bin_k: begin
               if (bus.key > 4'd1 || cnt_n == 3'd6) begin
                  st_n = ERR;
               end else begin
                  acc_n = {acc_n[6:0], bus.key[0]};
                  cnt_n = cnt_n + 3'd1;
               end
            end
            neg_k: begin
               if (nk_n) begin
                  st_n = ERR;
               end else begin
                  sg_n = 1'b1;
                  nk_n = 1'b1;
               end
            end
            dig_k: begin
               if (wide > lim) begin
                  st_n = ERR;
               end else begin
                  acc_n = wide[7:0];
                  nk_n  = 1'b1;
               end
            end
            default: ;
         endcase
      end

      case (st_n)
         IDLE: val_n = '0;
         ERR:  val_n = 12'hC00;
         OP1, OP2:
            val_n = pack(md_n, s1_n, m1_n, sg_n,
                         acc_n, st_n == OP2);
         DONE: begin
            if (commit) begin
               val_n = pack(md, fs1, m1, fsg,
                            acc, 1'b1);
               vv_n  = 1'b1;
            end
         end
         default: val_n = 12'hC00;
      endcase

      err_n  = (st_n == ERR);
      busy_n = (st_n == OP1) || (st_n == OP2);
   end

   // State, accumulators and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st            <= IDLE;
         md            <= 2'b00;
         acc           <= '0;
         sg            <= 1'b0;
         s1            <= 1'b0;
         m1            <= '0;
         cnt           <= '0;
         nk            <= 1'b0;
         bus.val       <= '0;
         bus.val_valid <= 1'b0;
         bus.err       <= 1'b0;
         bus.busy      <= 1'b0;
      end else begin
         st            <= st_n;
         md            <= md_n;
         acc           <= acc_n;
         sg            <= sg_n;
         s1            <= s1_n;
         m1            <= m1_n;
         cnt           <= cnt_n;
         nk            <= nk_n;
         bus.val       <= val_n;
         bus.val_valid <= vv_n;
         bus.err       <= err_n;
         bus.busy      <= busy_n;
      end
   end

endmodule

// File: doc/bcd_entry_to_val.md
Name: bcd_entry_to_val

Overview:
- Digit-entry assembler that turns keypad/switch key codes into the packed 12-bit display/operand word consumed by the BCD display decoder and the ALU operand path.
- Accumulates decimal or binary keys per operand, tracks sign, range-checks, and emits the packed word on commit.
- Drives a live preview on `val` so the display tracks entry in progress.

Parameters:
- NEG_CODE, 10, key code meaning "minus sign".
- MAG8_MAX, 255, upper magnitude limit in mode 01. Must be ≤255.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- key_valid  input  1  one key accepted per cycle when high.
- key  input  4  0-9 digit; NEG_CODE minus; other codes ignored.
- mode  input  2  format select: 00 two signed 4-bit; 01 signed 8-bit; 10 six binary digits; 11 invalid.
- enter  input  1  advance operand / commit (single-cycle strobe).
- clear  input  1  abandon entry, return to IDLE.
- val  output  12  packed word (live preview, final value after commit).
- val_valid  output  1  one-cycle pulse on commit.
- err  output  1  sticky error flag.
- busy  output  1  high in OP1/OP2.

Behaviour:
- Packed formats:
  - mode 00: {2'b00, s1, m1[3:0], s2, m2[3:0]}.
  - mode 01: {2'b01, s, 1'b0, m[7:0]}.
  - mode 10: {2'b10, 4'b0, b[5:0]}, right-justified.
  - Error word: 12'hC00.
- Reset: state IDLE; val=0, val_valid=0, err=0, busy=0; accumulators, sign and bit count cleared.
- All outputs are registered and update on the edge that samples the input. val_valid is high for exactly the cycle after the committing enter edge.
- Priority on one edge: clear > enter > key. A key presented with enter is dropped.
- States are IDLE, OP1, OP2, DONE, ERR.
  - IDLE/DONE, accepted key:
    - latch mode; clear accumulators, sign, count and err.
    - go to OP1 and process the key as its first key.
    - if latched mode=11, go to ERR.
    - Mode is ignored until the next entry start.
  - OP1/OP2, decimal digit d:
    - acc <= acc*10+d.
    - If the result exceeds 15 (mode 00) or MAG8_MAX (mode 01), go to ERR.
  - Minus key:
    - accepted only as the first key of an operand in mode 00/01; sets the sign.
    - anywhere else, go to ERR.
  - Mode 10 keys:
    - 0/1 shifts in LSB-first-position (acc <= {acc,key[0]}), count+1.
    - a digit 2-9, or a 7th bit, goes to ERR.
  - enter in OP1:
    - mode 00: go to OP2.
    - modes 01/10: commit, go to DONE.
  - enter in OP2: commit, go to DONE.
  - enter in IDLE/DONE: no effect.
  - An enter with no digits commits magnitude 0.
  - ERR: val=12'hC00, err=1, busy=0. All keys and enter are ignored; only clear or rst exits.
  - clear from any state: IDLE, val=0, err=0, val_valid=0.
- Preview: in OP1/OP2, val shows the current packed word; an operand not yet entered reads sign 0, magnitude 0.
- DONE holds the committed val until the next accepted key or clear.
- Ignored key codes (11-15, ≠NEG_CODE) never change state.
- Async rst mid-entry returns to reset values immediately, with no val_valid.

Optional Feature:
- Macro NEG_ZERO_FIX_EN.
  - Defined: at commit, any operand with magnitude 0 has its sign bit forced to 0, so "-0" is committed as +0.
  - Undefined: the sign bit is kept as entered. The preview is unaffected in both cases.

Test Plan:
- mode=00, keys NEG,1,2,enter,7,enter → val=12'h387; val_valid high exactly one cycle after the second enter; err=0; busy low after commit.
- mode=01, keys 2,5,5,enter → val=12'h4FF. New entry 2,5,6 → err=1 and val=12'hC00 on the "6" edge. Key 3 then does nothing; clear then gives val=0, err=0.
- mode=10, keys 1,0,1,1,enter → val=12'h80B. New entry of 7 binary keys → ERR on the 7th. Key 2 in mode 10 → ERR.
- mode=00, keys 1,6 → ERR on "6" (16>15). Key NEG after digit 3 → ERR. mode=11 with a first key → ERR.
- clear and key 5 in the same cycle → IDLE, val=0, key dropped. enter and key together → key dropped. rst asserted mid-OP2 → all outputs 0 asynchronously.
- mode=00, keys NEG,0,enter,0,enter → with NEG_ZERO_FIX_EN val=12'h000; without it val=12'h200.
